// File: rtl/pkt_src_arbiter.sv
// Round-robin arbiter forwarding one of NUM_SRC packet sources to the router input.
// Define PKT_ARB_PARITY_CHECK_EN to build the parity checker driving err_parity.
module pkt_src_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   req,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic                 busy,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 packet_valid,
    output logic [7:0]           data,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 err_parity
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOP = 2'd1;
    localparam logic [1:0] FWD      = 2'd2;
    localparam logic [1:0] GAP      = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         data_q, data_d;
    logic               pv_q, pv_d;
    logic               elen_q, elen_d;
    logic               eto_q, eto_d;

    logic [NUM_SRC-1:0] rot;
    logic [PW-1:0]      pick;
    logic               found;
    logic               sv_w;
    logic               rq_w;
    logic [7:0]         byte_w;
    logic               last_byte;
    logic [PW-1:0]      nxt_ptr;

    // Rotate requests so bit 0 is the source at ptr; first set bit wins.
    always_comb begin
        rot   = NUM_SRC'({req, req} >> ptr_q);
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr_q) + j) % NUM_SRC);
            end
        end
    end

    always_comb begin
        sv_w   = 1'b0;
        rq_w   = 1'b0;
        byte_w = 8'h00;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (win_q == PW'(s)) begin
                sv_w   = src_valid[s];
                rq_w   = req[s];
                byte_w = src_data[8*s +: 8];
            end
        end
    end

    assign last_byte = (cnt_q + 8'd1 == len_q);
    assign nxt_ptr   = (win_q == PW'(NUM_SRC - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        pv_d    = 1'b0;
        elen_d  = 1'b0;
        eto_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!busy && found) begin
                    win_d   = pick;
                    grant_d = NUM_SRC'(1) << pick;
                    cnt_d   = 8'd0;
                    state_d = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (sv_w) begin
                    pv_d    = 1'b1;
                    data_d  = byte_w;
                    len_d   = {2'b00, byte_w[7:2]} + 8'd2;
                    cnt_d   = 8'd1;
                    state_d = FWD;
                end else if (!rq_w) begin
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    eto_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FWD: begin
                pv_d   = sv_w;
                data_d = byte_w;
                if (!sv_w || last_byte) begin
                    elen_d  = !sv_w;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            data_q  <= 8'd0;
            pv_q    <= 1'b0;
            elen_q  <= 1'b0;
            eto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            pv_q    <= pv_d;
            elen_q  <= elen_d;
            eto_q   <= eto_d;
        end
    end

    assign grant        = grant_q;
    assign packet_valid = pv_q;
    assign data         = data_q;
    assign err_len      = elen_q;
    assign err_timeout  = eto_q;

`ifdef PKT_ARB_PARITY_CHECK_EN
    logic [7:0] par_q;
    logic       epar_q;

    // Running XOR over header and payload; compared against the final byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q  <= 8'd0;
            epar_q <= 1'b0;
        end else begin
            epar_q <= 1'b0;
            if (state_q == WAIT_SOP && sv_w) begin
                par_q <= byte_w;
            end else if (state_q == FWD && sv_w) begin
                if (last_byte) begin
                    epar_q <= (par_q != byte_w);
                end else begin
                    par_q <= par_q ^ byte_w;
                end
            end
        end
    end

    assign err_parity = epar_q;
`else
    assign err_parity = 1'b0;
`endif

endmodule

// File: doc/pkt_src_arbiter.md
# pkt_src_arbiter

Round-robin arbiter sharing the router's single byte-wide packet input among `NUM_SRC` packet sources. It grants one source at a time and forwards that source's packet stream onto the router's `packet_valid`/`data` input through one register stage. It also checks packet framing against the header length and enforces an idle gap between packets. It sits directly in front of the router input, in the same position the bench packet driver occupies.

## Interface
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `GAP_CYCLES`, 2: idle cycles forced between packets (1..15).
- `TIMEOUT`, 16: cycles a granted source may take to start its packet (2..255).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in `NUM_SRC`: per-source packet request, level; held until packet sent.
- `src_valid` in `NUM_SRC`: per-source byte-valid, high for contiguous packet bytes.
- `src_data` in `8*NUM_SRC`: per-source byte; source s uses bits [8s+7:8s].
- `busy` in 1: router input back-pressure.
- `grant` out `NUM_SRC`: one-hot grant; at most one bit high.
- `packet_valid` out 1: router packet_valid, registered.
- `data` out 8: router data byte, registered.
- `err_len` out 1: one-cycle pulse, packet ended before header length.
- `err_timeout` out 1: one-cycle pulse, granted source never started.
- `err_parity` out 1: one-cycle pulse, parity byte mismatch (see Configuration).

## Operation
- Packet format: header byte, then payload, then parity byte. Header [7:2] = payload length `len` (0..63). Header [1:0] = destination port. Total bytes L = `len`+2.
- Parity is even: XOR of header and all payload bytes equals the parity byte.
- FSM states: IDLE, WAIT_SOP, FWD, GAP.
- IDLE: if `busy`=0 and any `req` high, select winner w by searching upward from pointer `ptr` with wrap. Set `grant[w]` and go to WAIT_SOP. If `busy`=1, no grant is issued.
- WAIT_SOP:
  - `src_valid[w]`=1 → go to FWD; that byte is forwarded as the header.
  - `req[w]` drops with no valid → go to IDLE, no error.
  - TIMEOUT cycles elapse without valid → pulse `err_timeout` and go to GAP.
- FWD: each cycle, `packet_valid`<=`src_valid[w]` and `data`<=`src_data[w]`. The byte counter increments per forwarded byte, and L is latched from the header.
  - Counter reaches L → drop grant, go to GAP.
  - `src_valid[w]`=0 before L → pulse `err_len`, drop grant, go to GAP.
- `busy` is ignored in WAIT_SOP and FWD; a started packet is never stalled.
- GAP: counts GAP_CYCLES with `packet_valid`=0, then returns to IDLE.
- `ptr` <= (w+1) mod `NUM_SRC` whenever a grant ends, whether by completion, error, or req drop.
- Bytes a source presents while not granted are never forwarded.

## Timing
- Reset values: `grant`=0, `packet_valid`=0, `data`=0, all `err_*`=0, `ptr`=0, FSM in IDLE. Reset mid-packet clears these immediately, and the partial packet is truncated.
- Grant latency: `req` sampled at edge k → `grant` high after edge k.
- Data latency is 1 cycle: a byte sampled at edge j appears on `data` after edge j.
- The last byte is sampled at edge e. `grant` falls after edge e, and `packet_valid` falls after edge e+1.
- Minimum spacing between packets on the router side is GAP_CYCLES cycles with `packet_valid` low. The next grant follows GAP_CYCLES+1 edges after e.
- `err_*` pulses are high for exactly the cycle after the detecting edge.
- `len`=0 gives a 2-byte packet: header plus parity.

## Configuration
- `PKT_ARB_PARITY_CHECK_EN` defined: a running XOR accumulates over the header and payload. When the parity byte is sampled and does not match, `err_parity` pulses. The byte is still forwarded.
- Not defined: no parity logic is built, and `err_parity` is tied to 0.

## Test plan
- Single source: src0 req with header 8'h0D (`len`=3, port 1) plus 3 bytes plus correct parity → `grant`=4'b0001, 5 bytes on `data` 1 cycle delayed, no errors, `ptr`=1.
- All four `req` high, back-to-back 2-byte packets → grants in order 0,1,2,3,0, with ≥2 idle `packet_valid` cycles between packets.
- `busy`=1 while `req[2]`=1 → no grant. Release `busy` → `grant[2]` high after the next edge. Raising `busy` mid-packet does not interrupt the packet.
- Header `len`=5, `src_valid` drops after 4 bytes → `err_len` pulse, grant released, next source served.
- Granted source idle for 16 cycles → `err_timeout` pulse on the 16th cycle, `ptr` advances. Separately, a wrong parity byte with the macro defined → `err_parity` pulse.
- Assert `reset` during FWD → all outputs 0 at once; after release, the first grant goes to src0.
